// File: rtl/step_scheduler.sv
// step_scheduler: game-level sequencer for the snake field datapath.
//
// Emits a periodic one-cycle `step` pulse, waits out the field register
// latency, and, when an apple is requested, places it in a random empty cell
// by scanning the field map one cell per cycle. When no empty cell is left,
// the sequencer raises game_over and halts.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   enable_i       game running; only gates the tick counter
//   apple_eaten_i  one-cycle request for a new apple
//   rand_i         free-running random number
//   field_i        cell map, 2 bits per cell (00 empty, 01 snake, 10 apple, 11 block)
//   step_o         one-cycle pulse to the field calculator and snake logic
//   apple_valid_o  apple_x_o/apple_y_o hold a placed apple
//   apple_x_o      apple column
//   apple_y_o      apple row
//   busy_o         high while dividing or scanning
//   game_over_o    sticky; no empty cell found
module step_scheduler #(
  parameter int SIZE_X      = 10,
  parameter int SIZE_Y      = 10,
  parameter int FIELD_SIZE  = SIZE_X*SIZE_Y*2,
  parameter int STEP_PERIOD = 25000000,
  parameter int FIELD_LAT   = 1,
  parameter int RAND_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic                  apple_eaten_i,
  input  logic [RAND_W-1:0]     rand_i,
  input  logic [FIELD_SIZE-1:0] field_i,
  output logic                  step_o,
  output logic                  apple_valid_o,
  output logic [7:0]            apple_x_o,
  output logic [7:0]            apple_y_o,
  output logic                  busy_o,
  output logic                  game_over_o
);

  localparam int N  = SIZE_X*SIZE_Y;
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(STEP_PERIOD+1);
  localparam int LW = $clog2(FIELD_LAT+1);

  localparam logic [7:0]    SX8       = 8'(SIZE_X);
  localparam logic [7:0]    N8        = 8'(N);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N-1);
  localparam logic [15:0]   SCAN_LAST = 16'(N-1);
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_PERIOD-1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(FIELD_LAT-1);

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, STEP, SETTLE, PLACE_LOAD, PLACE_DIV, PLACE_SCAN, HALT
  } state_t;

  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [LW-1:0] settle_q;
  logic          pending_q;
  logic [7:0]    x_q, y_q;
  logic [IW-1:0] idx_q;
  logic [15:0]   scan_q;
  logic          step_q, valid_q, busy_q, over_q;
  logic [7:0]    apple_x_q, apple_y_q;

  // Split the flat field vector into per-cell codes for indexed lookup.
  logic [1:0] cells [N];
  for (genvar gi = 0; gi < N; gi++) begin : g_cells
    assign cells[gi] = field_i[2*gi +: 2];
  end

  logic [1:0] cell_d;
  logic [7:0] rand8_d;
  logic [7:0] start_d;

  assign cell_d  = cells[idx_q];
  assign rand8_d = 8'(rand_i);
  // 2^RAND_W < 2N, so a single conditional subtraction reduces rand into 0..N-1.
  assign start_d = (rand8_d >= N8) ? rand8_d - N8 : rand8_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      settle_q  <= '0;
      pending_q <= 1'b1;
      x_q       <= '0;
      y_q       <= '0;
      idx_q     <= '0;
      scan_q    <= '0;
      step_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      over_q    <= 1'b0;
      apple_x_q <= '0;
      apple_y_q <= '0;
    end else begin
      step_q    <= 1'b0;
      // A request arriving in any cycle is remembered; in PLACE_LOAD this is
      // overridden by a clear, unless a new request lands in that same cycle.
      pending_q <= pending_q | apple_eaten_i;

      case (state_q)
        IDLE: begin
          state_q <= pending_q ? PLACE_LOAD : WAIT_TICK;
        end

        WAIT_TICK: begin
          if (enable_i) begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              state_q <= STEP;
              step_q  <= 1'b1;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end

        STEP: begin
          settle_q <= '0;
          state_q  <= SETTLE;
        end

        SETTLE: begin
          if (settle_q == LAT_LAST) begin
            state_q <= pending_q ? PLACE_LOAD : WAIT_TICK;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end

        PLACE_LOAD: begin
          pending_q <= apple_eaten_i;
          x_q       <= start_d;
          y_q       <= '0;
          idx_q     <= IW'(start_d);
          scan_q    <= '0;
          valid_q   <= 1'b0;
          busy_q    <= 1'b1;
          state_q   <= PLACE_DIV;
        end

        // Repeated subtraction turns the linear start index into (x, y);
        // idx_q already holds y*SIZE_X+x and stays untouched.
        PLACE_DIV: begin
          if (x_q >= SX8) begin
            x_q <= x_q - SX8;
            y_q <= y_q + 1'b1;
          end else begin
            state_q <= PLACE_SCAN;
          end
        end

        PLACE_SCAN: begin
          if (cell_d == 2'b00) begin
            apple_x_q <= x_q;
            apple_y_q <= y_q;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= WAIT_TICK;
          end else if (scan_q == SCAN_LAST) begin
            over_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= HALT;
          end else begin
            scan_q <= scan_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              x_q   <= '0;
              y_q   <= '0;
              idx_q <= '0;
            end else if (x_q == SX8 - 8'd1) begin
              x_q   <= '0;
              y_q   <= y_q + 1'b1;
              idx_q <= idx_q + 1'b1;
            end else begin
              x_q   <= x_q + 1'b1;
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        HALT: begin
          state_q <= HALT;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign step_o        = step_q;
  assign apple_valid_o = valid_q;
  assign apple_x_o     = apple_x_q;
  assign apple_y_o     = apple_y_q;
  assign busy_o        = busy_q;
  assign game_over_o   = over_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Directed testbench for step_scheduler (10x10 field, STEP_PERIOD=4, FIELD_LAT=1).
module tb_step_scheduler;

  localparam int SX = 10;
  localparam int SY = 10;
  localparam int N  = SX*SY;
  localparam int FS = N*2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          apple_eaten = 1'b0;
  logic [6:0]    rand_v = '0;
  logic [FS-1:0] field = '0;
  logic          step, apple_valid, busy, game_over;
  logic [7:0]    apple_x, apple_y;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  step_scheduler #(
    .SIZE_X(SX), .SIZE_Y(SY), .FIELD_SIZE(FS),
    .STEP_PERIOD(4), .FIELD_LAT(1), .RAND_W(7)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable), .apple_eaten_i(apple_eaten),
    .rand_i(rand_v), .field_i(field), .step_o(step),
    .apple_valid_o(apple_valid), .apple_x_o(apple_x), .apple_y_o(apple_y),
    .busy_o(busy), .game_over_o(game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [FS-1:0] mk_field(input int a, input int b, input int c);
    logic [FS-1:0] f;
    f = '0;
    if (a >= 0) f[2*a +: 2] = 2'b01;
    if (b >= 0) f[2*b +: 2] = 2'b01;
    if (c >= 0) f[2*c +: 2] = 2'b01;
    return f;
  endfunction

  function automatic logic [FS-1:0] full_field();
    logic [FS-1:0] f;
    for (int i = 0; i < N; i++) f[2*i +: 2] = 2'b01;
    return f;
  endfunction

  task automatic do_reset(input string tag, input logic [6:0] r, input logic [FS-1:0] f);
    @(negedge clk);
    rand_v = r;
    field  = f;
    rst    = 1'b1;
    #1;
    check_val({tag, "_rst_outs"},
              32'({step, apple_valid, busy, game_over, apple_x, apple_y}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic place_wait(input string tag, output int busy_n, output int steps_n);
    bit done;
    done = 1'b0;
    busy_n = 0;
    steps_n = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (busy) busy_n++;
      if (step) steps_n++;
      if (apple_valid && !busy) done = 1'b1;
    end
    check_val({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_step(input string tag, output int at);
    bit seen;
    seen = 1'b0;
    at = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (step) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    check_val({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  int bn, sn, c1, c2, c3, go_seen;

  initial begin
    // rand=37, empty field: 3 subtractions -> (7,3); busy = 4 div + 1 scan
    do_reset("t1", 7'd37, '0);
    place_wait("t1", bn, sn);
    $display("t1 rand=37 x=%0d y=%0d busy=%0d steps=%0d", apple_x, apple_y, bn, sn);
    check_val("t1_x", 32'(apple_x), 32'd7);
    check_val("t1_y", 32'(apple_y), 32'd3);
    check_val("t1_busy", 32'(bn), 32'd5);
    check_val("t1_steps", 32'(sn), 32'd0);

    // rand=105 reduces to 5: no subtraction, busy = 1 div + 1 scan
    do_reset("t2", 7'd105, '0);
    place_wait("t2", bn, sn);
    $display("t2 rand=105 x=%0d y=%0d busy=%0d", apple_x, apple_y, bn);
    check_val("t2_x", 32'(apple_x), 32'd5);
    check_val("t2_y", 32'(apple_y), 32'd0);
    check_val("t2_busy", 32'(bn), 32'd2);

    // cells 37..39 occupied: scan lands on cell 40 -> (0,4); busy = 4 + 4
    do_reset("t3a", 7'd37, mk_field(37, 38, 39));
    place_wait("t3a", bn, sn);
    $display("t3a x=%0d y=%0d busy=%0d", apple_x, apple_y, bn);
    check_val("t3a_x", 32'(apple_x), 32'd0);
    check_val("t3a_y", 32'(apple_y), 32'd4);
    check_val("t3a_busy", 32'(bn), 32'd8);

    // wrap: cells 98,99,0 occupied, rand=98 -> (1,0); busy = 10 + 4
    do_reset("t3b", 7'd98, mk_field(98, 99, 0));
    place_wait("t3b", bn, sn);
    $display("t3b x=%0d y=%0d busy=%0d", apple_x, apple_y, bn);
    check_val("t3b_x", 32'(apple_x), 32'd1);
    check_val("t3b_y", 32'(apple_y), 32'd0);
    check_val("t3b_busy", 32'(bn), 32'd14);
    check_val("t3b_steps", 32'(sn), 32'd0);

    // step period 4+1+1 = 6; enable low for 3 WAIT_TICK cycles -> 9
    wait_step("t4a", c1);
    wait_step("t4b", c2);
    $display("t4 period=%0d", c2 - c1);
    check_val("t4_period", 32'(c2 - c1), 32'd6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    enable = 1'b1;
    wait_step("t4c", c3);
    $display("t4 delayed period=%0d", c3 - c2);
    check_val("t4_delayed", 32'(c3 - c2), 32'd9);
    check_val("t4_valid_kept", 32'(apple_valid), 32'd1);

    // full field: request apple mid-WAIT_TICK, place after next step -> game over
    field  = full_field();
    rand_v = 7'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    apple_eaten = 1'b1;
    @(posedge clk); #1;
    apple_eaten = 1'b0;
    wait_step("t5", c1);
    bn = 0;
    go_seen = 0;
    for (int i = 0; i < 300 && go_seen == 0; i++) begin
      @(posedge clk); #1;
      if (busy) bn++;
      if (game_over) go_seen = 1;
    end
    $display("t5 game_over=%0d valid=%0d busy=%0d", game_over, apple_valid, bn);
    check_val("t5_game_over", 32'(go_seen), 32'd1);
    check_val("t5_valid", 32'(apple_valid), 32'd0);
    check_val("t5_busy", 32'(bn), 32'd101);
    sn = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (step) sn++;
    end
    $display("t5 steps after halt=%0d", sn);
    check_val("t5_no_steps", 32'(sn), 32'd0);
    check_val("t5_sticky", 32'(game_over), 32'd1);

    // async reset mid-scan, then fresh placement without a step
    do_reset("t6", 7'd0, full_field());
    repeat (10) begin
      @(posedge clk); #1;
    end
    check_val("t6_scanning", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    $display("t6 async rst busy=%0d valid=%0d", busy, apple_valid);
    check_val("t6_async_outs",
              32'({step, apple_valid, busy, game_over, apple_x, apple_y}), 32'd0);
    field  = '0;
    rand_v = 7'd50;
    @(negedge clk);
    rst = 1'b0;
    place_wait("t6", bn, sn);
    $display("t6 x=%0d y=%0d busy=%0d steps=%0d", apple_x, apple_y, bn, sn);
    check_val("t6_x", 32'(apple_x), 32'd0);
    check_val("t6_y", 32'(apple_y), 32'd5);
    check_val("t6_busy", 32'(bn), 32'd7);
    check_val("t6_steps", 32'(sn), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_scheduler.md
Name: step_scheduler

Overview:
- Game-level sequencer for the snake field datapath.
- Generates the periodic `step` pulse that makes the field calculator rebuild the field.
- Waits out the field register latency, then places an apple in a random empty cell by scanning the field vector.
- Flags game over when no empty cell exists.

Parameters:
- SIZE_X, 10, field width in cells.
- SIZE_Y, 10, field height in cells.
- FIELD_SIZE, SIZE_X*SIZE_Y*2, field vector width (2 bits per cell).
- STEP_PERIOD, 25000000, clk cycles spent in WAIT_TICK between steps (>=1).
- FIELD_LAT, 1, cycles from `step` until the `field` input is valid (>=1).
- RAND_W, 7, random input width; 2^RAND_W must be < 2*SIZE_X*SIZE_Y.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous and active-high.
- enable  input  1  game running; gates the tick counter only.
- apple_eaten  input  1  single-cycle pulse from snake logic: request a new apple.
- rand  input  RAND_W  free-running random number.
- field  input  FIELD_SIZE  cell map; 00 empty, 01 snake, 10 apple, 11 block.
- step  output  1  one-cycle pulse to the field calculator and snake logic.
- apple_valid  output  1  apple_x/apple_y hold a placed apple.
- apple_x  output  8  apple column.
- apple_y  output  8  apple row.
- busy  output  1  high in PLACE_DIV or PLACE_SCAN.
- game_over  output  1  sticky; no empty cell found.

Behaviour:
- Reset (asynchronous, immediate):
  - step=0, apple_valid=0, apple_x=0, apple_y=0, busy=0, game_over=0.
  - Tick counter=0, place_pending=1, state=IDLE.
- States: IDLE, WAIT_TICK, STEP, SETTLE, PLACE_LOAD, PLACE_DIV, PLACE_SCAN, HALT.
- IDLE: next cycle goes to PLACE_LOAD if place_pending, else WAIT_TICK.
- WAIT_TICK:
  - While enable=1, the counter increments; at count==STEP_PERIOD-1 it clears and goes to STEP.
  - While enable=0, the counter holds its value.
- STEP: step=1 for exactly this cycle; go to SETTLE.
- SETTLE: stay FIELD_LAT cycles, then go to PLACE_LOAD if place_pending, else WAIT_TICK.
  - Step-to-step period with no placement = STEP_PERIOD+1+FIELD_LAT cycles.
- place_pending:
  - Set by apple_eaten in any cycle.
  - Cleared in PLACE_LOAD.
  - If apple_eaten and the clear occur in the same cycle, set wins.
- PLACE_LOAD (1 cycle):
  - r = rand, minus N if rand>=N (N=SIZE_X*SIZE_Y).
  - x<=r, y<=0, scan_cnt<=0, apple_valid<=0; go to PLACE_DIV.
- PLACE_DIV:
  - While x>=SIZE_X: x<=x-SIZE_X, y<=y+1, one subtraction per cycle.
  - Exit when x<SIZE_X, in the same cycle the check fails, to PLACE_SCAN; maximum SIZE_Y cycles.
  - The linear index idx = y*SIZE_X+x is tracked alongside x and y.
- PLACE_SCAN, one cell per cycle:
  - If field[2*idx+1:2*idx]==00: apple_x<=x, apple_y<=y, apple_valid<=1; go to WAIT_TICK.
  - Otherwise advance with raster wrap: x+1; at SIZE_X-1, x wraps to 0 and y increments; at the last cell, wrap to (0,0), idx=0.
  - If scan_cnt==N-1 with no empty cell found: game_over<=1; go to HALT.
- HALT: absorbing; no further step pulses; only rst leaves it.
- enable=0 during placement: placement still completes.
- The tick counter does not run during placement.
- apple_eaten during a scan: latched and serviced after the next step.
- Widths: x and y counters are 8-bit; scan_cnt is 16-bit; arithmetic is unsigned.

Test Plan:
- Reset release, field all 00, rand=37 → PLACE_DIV takes 3 subtractions → apple_valid=1, apple_x=7, apple_y=3; step stays 0 throughout.
- rand=105, field all 00 → index reduced to 5 → apple_x=5, apple_y=0; no division cycles.
- Cells 37..39 = 01, rand=37 → apple_x=0, apple_y=4 after 3 scan cycles; wrap case: cells 98, 99, 0 occupied, rand=98 → apple_x=1, apple_y=0.
- STEP_PERIOD=4, FIELD_LAT=1, enable=1, no apple_eaten → step pulses exactly every 6 cycles; enable low for 3 cycles → the next pulse is delayed by 3.
- All 100 cells = 01, apple_eaten pulse → after the next step, 100 scan cycles → game_over=1, apple_valid=0, and no further step pulses for 50 cycles.
- rst asserted between clock edges mid-scan → all outputs 0 before the next edge; after release, a fresh placement occurs with no step first.
